// File: rtl/dds_mod_pkg.sv
// dds_mod_pkg: mode codes, state encoding and default LFSR constants for the DDS modulation chain
package dds_mod_pkg;
  typedef enum logic [1:0] {MODE_RAW = 2'd0, MODE_ASK = 2'd1, MODE_BPSK = 2'd2, MODE_FSK = 2'd3} mode_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam logic [4:0] LFSR_TAPS_DEF = 5'b10100;
  localparam logic [4:0] LFSR_SEED_DEF = 5'b00001;
endpackage

// File: rtl/dds_lfsr.sv
// dds_lfsr: Fibonacci PRBS LFSR that shifts left one place per step with the feedback bit entering bit 0
module dds_lfsr
  import dds_mod_pkg::*;
#(
  parameter int W = 5,
  parameter logic [W-1:0] TAPS = LFSR_TAPS_DEF,
  parameter logic [W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] S = (SEED == '0) ? {{(W-1){1'b0}}, 1'b1} : SEED;
  logic [W-1:0] q_d, q_q;
  always_comb q_d = (q_q == '0) ? S : step ? {q_q[W-2:0], ^(q_q & TAPS)} : q_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q_q <= S;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/dds_mod_scheduler.sv
// dds_mod_scheduler: symbol-rate sequencer dividing the DDS sample strobe and stepping a PRBS per symbol
module dds_mod_scheduler
  import dds_mod_pkg::*;
#(
  parameter int DIV_W = 20,
  parameter int LFSR_W = 5,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_TAPS_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter int PINC_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [PINC_W-1:0] cfg_pinc0,
  input  logic [PINC_W-1:0] cfg_pinc1,
  output logic              sym_strobe,
  output logic              lfsr_bit,
  output logic [1:0]        mod_sel,
  output logic              ask_gate,
  output logic [PINC_W-1:0] phase_inc,
  output logic              busy
);
  localparam logic [LFSR_W-1:0] SEED_F = (LFSR_SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : LFSR_SEED;
  typedef struct packed {
    mode_e             mode;
    logic [DIV_W-1:0]  div;
    logic [PINC_W-1:0] pinc0;
    logic [PINC_W-1:0] pinc1;
  } cfg_t;
  state_e            state_q, state_d;
  logic [DIV_W-1:0]  count_q, count_d;
  cfg_t              act_q, act_d, shd_q, shd_d, cfg_in;
  logic              shv_q, shv_d, sym_q, sym_d, gate_q, gate_d;
  logic [PINC_W-1:0] pinc_q, pinc_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic              run, boundary, hs, commit, bit_d;
  dds_lfsr #(.W(LFSR_W), .TAPS(LFSR_TAPS), .SEED(SEED_F)) u_lfsr (
    .clk(clk), .reset_n(reset_n), .step(boundary), .q(lfsr_q)
  );
  always_comb begin
    run = state_q == RUN;
    boundary = run & sample_en & (count_q == act_q.div);
    cfg_ready = !run | !shv_q;
    hs = cfg_valid & cfg_ready;
    commit = shv_q & (boundary | !enable | !run);
    cfg_in = '{mode: mode_e'(cfg_mode), div: cfg_div, pinc0: cfg_pinc0, pinc1: cfg_pinc1};
    state_d = enable ? RUN : IDLE;
    count_d = (!run | !enable | boundary) ? '0 : count_q + DIV_W'(sample_en);
    shv_d = run & (hs | (shv_q & !commit));
    shd_d = (run & hs) ? cfg_in : shd_q;
    act_d = (!run & hs) ? cfg_in : commit ? shd_q : act_q;
    sym_d = boundary;
    bit_d = (lfsr_q == '0) ? SEED_F[0] : boundary ? ^(lfsr_q & LFSR_TAPS) : lfsr_q[0];
    gate_d = (state_d == RUN) & ((act_d.mode == MODE_ASK) ? bit_d : 1'b1);
    pinc_d = (state_d != RUN) ? '0 : (act_d.mode == MODE_FSK && bit_d) ? act_d.pinc1 : act_d.pinc0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      act_q <= '0;
      shd_q <= '0;
      shv_q <= 1'b0;
      sym_q <= 1'b0;
      gate_q <= 1'b0;
      pinc_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      act_q <= act_d;
      shd_q <= shd_d;
      shv_q <= shv_d;
      sym_q <= sym_d;
      gate_q <= gate_d;
      pinc_q <= pinc_d;
    end
  assign sym_strobe = sym_q;
  assign lfsr_bit = lfsr_q[0];
  assign mod_sel = act_q.mode;
  assign ask_gate = gate_q;
  assign phase_inc = pinc_q;
  assign busy = state_q == RUN;
endmodule

// File: tb/tb_dds_mod_scheduler.sv
// tb_dds_mod_scheduler: directed self-checking bench for the symbol-rate sequencer
module tb_dds_mod_scheduler;
  logic        clk = 1'b0;
  logic        reset_n, enable, sample_en, cfg_valid, cfg_ready;
  logic [1:0]  cfg_mode, mod_sel;
  logic [19:0] cfg_div;
  logic [31:0] cfg_pinc0, cfg_pinc1, phase_inc;
  logic        sym_strobe, lfsr_bit, ask_gate, busy;
  int          tests = 0, fails = 0, k = 0;
  logic [0:30] seq = 31'b1001011001111100011011101010000;
  logic [0:31] rec;
  always #5 clk = ~clk;
  dds_mod_scheduler dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_en(sample_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .cfg_pinc0(cfg_pinc0), .cfg_pinc1(cfg_pinc1), .sym_strobe(sym_strobe), .lfsr_bit(lfsr_bit),
    .mod_sel(mod_sel), .ask_gate(ask_gate), .phase_inc(phase_inc), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_sym"}, 64'(sym_strobe), 64'(0));
    chk({tag, "_bit"}, 64'(lfsr_bit), 64'(1));
    chk({tag, "_mode"}, 64'(mod_sel), 64'(0));
    chk({tag, "_gate"}, 64'(ask_gate), 64'(0));
    chk({tag, "_pinc"}, 64'(phase_inc), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ready"}, 64'(cfg_ready), 64'(1));
  endtask
  initial begin
    reset_n = 1'b0; enable = 1'b0; sample_en = 1'b0; cfg_valid = 1'b0;
    cfg_mode = 2'd0; cfg_div = '0; cfg_pinc0 = '0; cfg_pinc1 = '0;
    repeat (2) tick();
    chk_reset("rst");
    reset_n = 1'b1;
    tick();
    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_div = 20'd3; cfg_pinc0 = 32'h100; cfg_pinc1 = 32'h0;
    tick();
    cfg_valid = 1'b0;
    chk("t1_idle_mode", 64'(mod_sel), 64'(2));
    chk("t1_idle_pinc", 64'(phase_inc), 64'(0));
    chk("t1_idle_busy", 64'(busy), 64'(0));
    enable = 1'b1; sample_en = 1'b1;
    tick();
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_pinc", 64'(phase_inc), 64'h100);
    chk("t1_gate", 64'(ask_gate), 64'(1));
    chk("t1_sym0", 64'(sym_strobe), 64'(0));
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 4 == 0) k++;
      chk("t1_sym", 64'(sym_strobe), 64'(c % 4 == 0));
      chk("t1_bit", 64'(lfsr_bit), 64'(seq[k % 31]));
    end
    for (int s = 0; s < 32; s++) begin
      repeat (3) begin
        tick();
        chk("t2_sym_low", 64'(sym_strobe), 64'(0));
      end
      tick();
      k++;
      rec[s] = lfsr_bit;
      chk("t2_sym", 64'(sym_strobe), 64'(1));
      chk("t2_bit", 64'(lfsr_bit), 64'(seq[k % 31]));
      chk("t2_nonzero", 64'(dut.u_lfsr.q_q != 5'd0), 64'(1));
    end
    chk("t2_period", 64'(rec[31]), 64'(rec[0]));
    repeat (3) tick();
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_div = 20'd1; cfg_pinc0 = 32'h55; cfg_pinc1 = 32'h0;
    chk("t4_ready_pre", 64'(cfg_ready), 64'(1));
    tick();
    k++;
    cfg_valid = 1'b0;
    chk("t4_sym", 64'(sym_strobe), 64'(1));
    chk("t4_old_mode", 64'(mod_sel), 64'(2));
    chk("t4_ready_full", 64'(cfg_ready), 64'(0));
    repeat (3) begin
      tick();
      chk("t4_sym_low", 64'(sym_strobe), 64'(0));
      chk("t4_mode_hold", 64'(mod_sel), 64'(2));
    end
    tick();
    k++;
    chk("t4_sym2", 64'(sym_strobe), 64'(1));
    chk("t4_new_mode", 64'(mod_sel), 64'(1));
    chk("t4_ready", 64'(cfg_ready), 64'(1));
    chk("t4_gate", 64'(ask_gate), 64'(seq[k % 31]));
    chk("t4_pinc", 64'(phase_inc), 64'h55);
    cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_div = 20'd1; cfg_pinc0 = 32'h10; cfg_pinc1 = 32'h20;
    tick();
    cfg_valid = 1'b0;
    chk("t3_sym_low", 64'(sym_strobe), 64'(0));
    chk("t3_ready", 64'(cfg_ready), 64'(0));
    chk("t3_mode_hold", 64'(mod_sel), 64'(1));
    chk("t3_gate_hold", 64'(ask_gate), 64'(seq[k % 31]));
    tick();
    k++;
    chk("t3_sym", 64'(sym_strobe), 64'(1));
    chk("t3_mode", 64'(mod_sel), 64'(3));
    chk("t3_ready2", 64'(cfg_ready), 64'(1));
    chk("t3_gate", 64'(ask_gate), 64'(1));
    chk("t3_pinc", 64'(phase_inc), seq[k % 31] ? 64'h20 : 64'h10);
    for (int s = 0; s < 6; s++) begin
      tick();
      chk("t3_sym_low2", 64'(sym_strobe), 64'(0));
      chk("t3_pinc_hold", 64'(phase_inc), seq[k % 31] ? 64'h20 : 64'h10);
      tick();
      k++;
      chk("t3_sym2", 64'(sym_strobe), 64'(1));
      chk("t3_bit", 64'(lfsr_bit), 64'(seq[k % 31]));
      chk("t3_pinc_fsk", 64'(phase_inc), seq[k % 31] ? 64'h20 : 64'h10);
    end
    cfg_valid = 1'b1; cfg_mode = 2'd3; cfg_div = 20'd2; cfg_pinc0 = 32'h10; cfg_pinc1 = 32'h20;
    tick();
    cfg_valid = 1'b0;
    chk("t5_sym_low", 64'(sym_strobe), 64'(0));
    chk("t5_ready", 64'(cfg_ready), 64'(0));
    tick();
    k++;
    chk("t5_commit", 64'(sym_strobe), 64'(1));
    chk("t5_ready2", 64'(cfg_ready), 64'(1));
    for (int c = 1; c <= 27; c++) begin
      sample_en = (c % 3 == 0);
      tick();
      if (c % 9 == 0) k++;
      chk("t5_sym", 64'(sym_strobe), 64'(c % 9 == 0));
      chk("t5_count", 64'(dut.count_q), 64'((c % 9) / 3));
    end
    chk("t5_bit", 64'(lfsr_bit), 64'(seq[k % 31]));
    sample_en = 1'b1;
    cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_div = 20'd2; cfg_pinc0 = 32'h33; cfg_pinc1 = 32'h0;
    tick();
    cfg_valid = 1'b0; sample_en = 1'b0;
    chk("t6_ready", 64'(cfg_ready), 64'(0));
    chk("t6_sym_low", 64'(sym_strobe), 64'(0));
    enable = 1'b0;
    tick();
    chk("t6_idle_busy", 64'(busy), 64'(0));
    chk("t6_idle_gate", 64'(ask_gate), 64'(0));
    chk("t6_idle_pinc", 64'(phase_inc), 64'(0));
    chk("t6_idle_mode", 64'(mod_sel), 64'(0));
    chk("t6_idle_ready", 64'(cfg_ready), 64'(1));
    chk("t6_idle_bit", 64'(lfsr_bit), 64'(seq[k % 31]));
    enable = 1'b1;
    tick();
    chk("t6_run_busy", 64'(busy), 64'(1));
    chk("t6_run_pinc", 64'(phase_inc), 64'h33);
    chk("t6_run_gate", 64'(ask_gate), 64'(1));
    chk("t6_run_bit", 64'(lfsr_bit), 64'(seq[k % 31]));
    sample_en = 1'b1;
    repeat (2) begin
      tick();
      chk("t6_sym_low2", 64'(sym_strobe), 64'(0));
    end
    tick();
    k++;
    chk("t6_sym", 64'(sym_strobe), 64'(1));
    chk("t6_bit", 64'(lfsr_bit), 64'(seq[k % 31]));
    tick();
    reset_n = 1'b0;
    #1;
    chk_reset("t6_arst");
    enable = 1'b0; sample_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk_reset("t6_post");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
